addsub_chunked: RTL and testbench

- Parametrised, multi-cycle adder/subtractor; successor to the combinational ripple add/sub blocks.
- Processes a W-bit operand pair CHUNK bits per clock, carrying or borrowing between cycles in a register.
- This trades latency for a short carry chain, so wide datapaths close timing.
- Valid/ready on both sides; sits between operand staging and result registers in the arithmetic datapath.

---
 rtl/addsub_chunked.sv | 130 +++++++++++++
 tb/tb_addsub_chunked.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_chunked.sv
// addsub_chunked: multi-cycle W-bit adder/subtractor, CHUNK bits per clock.
// Carry/borrow ripples between cycles through a one-bit register.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   in_valid/in_ready operand handshake (ready only when idle)
//   a, b, mode, cin   operands; mode 0 = add, 1 = subtract
//   out_valid/out_ready result handshake
//   result, cout      sum/difference mod 2^W, carry-out / borrow-out
//   overflow          two's-complement signed overflow
//   busy              operation in flight or result waiting
//
// Build option: define ADDSUB_CHUNKED_SAT_EN to saturate the result to
// the signed limit on overflow (default: wrap modulo 2^W).

module addsub_chunked #(
   parameter int W     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         mode,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         overflow,
   output logic         busy
);

   localparam int NCH = W / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_n;

   logic [IW-1:0]  idx;
   logic           carry;
   logic           mode_q;
   logic [W-1:0]   areg;
   logic [W-1:0]   breg;

   logic [CHUNK-1:0] ach;
   logic [CHUNK-1:0] bch;
   logic [CHUNK:0]   sum;
   logic             last;
   logic             accept;
   logic             ovf_n;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (in_valid) state_n = RUN;
         RUN:  if (last) state_n = DONE;
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign last      = (state == RUN) && (idx == LAST);

   // ---------------- chunk adder ----------------
   always_comb begin
      ach = areg[idx*CHUNK +: CHUNK];
      bch = breg[idx*CHUNK +: CHUNK];
      sum = {1'b0, ach} + {1'b0, bch}
          + {{CHUNK{1'b0}}, carry};
   end

   // Sign of the final result is the top bit of the last chunk's sum.
   assign ovf_n = (areg[W-1] == breg[W-1]) &&
                  (sum[CHUNK-1] != areg[W-1]);

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= '0;
         carry    <= 1'b0;
         mode_q   <= 1'b0;
         areg     <= '0;
         breg     <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         // Subtract as a + ~b + 1, with borrow-in folded into the +1.
         areg   <= a;
         breg   <= mode ? ~b : b;
         mode_q <= mode;
         carry  <= mode ? ~cin : cin;
         idx    <= '0;
      end else if (state == RUN) begin
         result[idx*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
         carry <= sum[CHUNK];
         idx   <= idx + 1'b1;
         if (last) begin
            cout     <= mode_q ? ~sum[CHUNK] : sum[CHUNK];
            overflow <= ovf_n;
`ifdef ADDSUB_CHUNKED_SAT_EN
            if (ovf_n) begin
               result <= areg[W-1] ? {1'b1, {(W-1){1'b0}}}
                                   : {1'b0, {(W-1){1'b1}}};
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked: directed self-checking bench for addsub_chunked
// (W=32, CHUNK=8).

module tb_addsub_chunked;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        mode;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        cout;
   logic        overflow;
   logic        busy;

   int total = 0;
   int bad   = 0;

   addsub_chunked #(.W(32), .CHUNK(8)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .mode(mode),
      .cin(cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .cout(cout),
      .overflow(overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic start_op(input string tag,
                           input logic [31:0] ta,
                           input logic [31:0] tb_,
                           input logic tm,
                           input logic tc);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_rdy_to"}, 32'(n < 50), 32'd1);
      a = ta; b = tb_; mode = tm; cin = tc;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ta; b = ~tb_; mode = ~tm; cin = ~tc;
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_done_to"}, 32'(n < 50), 32'd1);
   endtask

   task automatic finish_op;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag,
                         input logic [31:0] ta,
                         input logic [31:0] tb_,
                         input logic tm,
                         input logic tc,
                         input logic [31:0] er,
                         input logic ec,
                         input logic eo);
      int n;
      start_op(tag, ta, tb_, tm, tc);
      wait_done(tag, n);
      check({tag, "_lat"}, 32'(n), 32'd4);
      check({tag, "_res"}, result, er);
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_ovf"}, 32'(overflow), 32'(eo));
      finish_op();
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      check({tag, "_ov0"}, 32'(out_valid), 32'd0);
   endtask

   logic [31:0] sat_add;
   logic [31:0] sat_sub;

   initial begin
      int n;
      logic [31:0] held;
`ifdef ADDSUB_CHUNKED_SAT_EN
      sat_add = 32'h7FFFFFFF;
      sat_sub = 32'h80000000;
`else
      sat_add = 32'h80000000;
      sat_sub = 32'h7FFFFFFF;
`endif
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; mode = 1'b0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", 32'(in_ready), 32'd1);
      check("rst_ov", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res", result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("wrap", 32'hFFFFFFFF, 32'h1, 0, 0,
             32'h0, 1, 0);
      run_op("cbnd", 32'h000000FF, 32'h1, 0, 0,
             32'h100, 0, 0);
      run_op("sub57", 32'h5, 32'h7, 1, 0,
             32'hFFFFFFFE, 1, 0);
      run_op("ovfadd", 32'h7FFFFFFF, 32'h1, 0, 0,
             sat_add, 0, 1);
      run_op("ovfsub", 32'h80000000, 32'h1, 1, 0,
             sat_sub, 0, 1);
      run_op("bin", 32'h10, 32'h1, 1, 1,
             32'hE, 0, 0);
      run_op("cin1", 32'h1, 32'h1, 0, 1,
             32'h3, 0, 0);

      // backpressure in DONE with in_valid pulsing
      start_op("bp", 32'h100, 32'h200, 0, 0);
      wait_done("bp", n);
      held = 32'h300;
      for (int i = 0; i < 6; i++) begin
         a = 32'h1111 * i; b = 32'h7;
         in_valid = i[0];
         @(posedge clk); #1;
         check("bp_res", result, held);
         check("bp_ov", 32'(out_valid), 32'd1);
         check("bp_rdy", 32'(in_ready), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
      end
      in_valid = 1'b0;
      finish_op();
      check("bp_rdy1", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("bp_noacc", 32'(busy), 32'd0);

      // reset in the second RUN cycle
      start_op("rr", 32'hDEADBEEF, 32'h12345678, 0, 0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("rr_ov", 32'(out_valid), 32'd0);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_rdy", 32'(in_ready), 32'd1);
      check("rr_res", result, 32'd0);
      check("rr_cout", 32'(cout), 32'd0);
      check("rr_ovf", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rr_hold", 32'(out_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op("post", 32'h12345678, 32'h11111111, 0, 0,
             32'h23456789, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
